stdmacro_reset_gen: RTL

Reset producer for the DFF standard-macro layer. It takes the chip-level asynchronous active-high reset and produces clean reset outputs in both polarities, so every `stdmacro_dff` configuration (high or low, sync or async) can be driven from it. The outputs assert asynchronously, deassert synchronously, and are stretched by a programmable hold count. A software reset request/acknowledge handshake lets the core re-enter reset without toggling the chip reset pin.

---
 rtl/stdmacro_reset_gen_pkg.sv | 21 ++
 rtl/stdmacro_reset_gen_sync.sv | 24 ++
 rtl/stdmacro_reset_gen.sv | 93 +++++++++
 3 files changed

// File: rtl/stdmacro_reset_gen_pkg.sv
// Shared definitions for the reset generator: FSM state encodings, default
// parameter values and the hold-counter width helper.
package stdmacro_reset_gen_pkg;

  typedef enum logic [1:0] {
    RSTGEN_HOLD  = 2'd0,
    RSTGEN_RUN   = 2'd1,
    RSTGEN_SWRST = 2'd2
  } rstgen_state_e;

  localparam int RSTGEN_SYNC_STAGES_DEF = 2;
  localparam int RSTGEN_HOLD_CYCLES_DEF = 16;

  // The counter needs at least one bit even when HOLD_CYCLES is 1.
  function automatic int rstgen_cnt_width(input int hold_cycles);
    int w;
    w = $clog2(hold_cycles);
    return (w < 1) ? 1 : w;
  endfunction

endpackage

// File: rtl/stdmacro_reset_gen_sync.sv
// Async-clear shift-chain synchroniser. It releases sync_ok STAGES edges
// after reset falls.
module std_reset_sync #(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic reset,
  output logic sync_ok
);

  logic [STAGES-1:0] chain_r;

  // Shift ones in behind the cleared chain; reset clears it asynchronously.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      chain_r <= {STAGES{1'b0}};
    end else begin
      chain_r <= {chain_r[STAGES-2:0], 1'b1};
    end
  end

  assign sync_ok = chain_r[STAGES-1];

endmodule

// File: rtl/stdmacro_reset_gen.sv
// Reset producer. Outputs assert asynchronously and deassert synchronously
// after a hold count. A soft reset is available through a req/ack handshake.
module stdmacro_reset_gen
  import stdmacro_reset_gen_pkg::*;
#(
  parameter int SYNC_STAGES = RSTGEN_SYNC_STAGES_DEF,
  parameter int HOLD_CYCLES = RSTGEN_HOLD_CYCLES_DEF
) (
  input  logic clk,
  input  logic reset,
  input  logic sw_reset_req,
  output logic sw_reset_ack,
  output logic reset_out,
  output logic resetn_out,
  output logic reset_done
);

  localparam int CNT_W = rstgen_cnt_width(HOLD_CYCLES);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(HOLD_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1'b1);
  localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};

  if (SYNC_STAGES < 2 || HOLD_CYCLES < 1) begin : g_bad_param
    $error("stdmacro_reset_gen: SYNC_STAGES must be >= 2 and HOLD_CYCLES >= 1");
  end

  rstgen_state_e    state_r;
  logic [CNT_W-1:0] cnt_r;
  logic             sync_ok_s;

  std_reset_sync #(.STAGES(SYNC_STAGES)) u_sync (
    .clk     (clk),
    .reset   (reset),
    .sync_ok (sync_ok_s)
  );

  // Hold/run/soft-reset sequencing. Every output comes straight off a flop.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r      <= RSTGEN_HOLD;
      cnt_r        <= CNT_ZERO;
      reset_out    <= 1'b1;
      resetn_out   <= 1'b0;
      sw_reset_ack <= 1'b0;
      reset_done   <= 1'b0;
    end else begin
      sw_reset_ack <= 1'b0;
      reset_done   <= 1'b0;
      case (state_r)
        RSTGEN_HOLD: begin
          if (sync_ok_s) begin
            if (cnt_r == CNT_LAST) begin
              state_r    <= RSTGEN_RUN;
              reset_out  <= 1'b0;
              resetn_out <= 1'b1;
              reset_done <= 1'b1;
            end else begin
              cnt_r <= cnt_r + CNT_ONE;
            end
          end
        end
        RSTGEN_RUN: begin
          if (sw_reset_req) begin
            state_r      <= RSTGEN_SWRST;
            cnt_r        <= CNT_ZERO;
            reset_out    <= 1'b1;
            resetn_out   <= 1'b0;
            sw_reset_ack <= 1'b1;
          end
        end
        RSTGEN_SWRST: begin
          // Clearing on exit keeps a 1-bit counter at zero when HOLD_CYCLES is 1.
          if (cnt_r == CNT_LAST) begin
            state_r    <= RSTGEN_RUN;
            cnt_r      <= CNT_ZERO;
            reset_out  <= 1'b0;
            resetn_out <= 1'b1;
            reset_done <= 1'b1;
          end else begin
            cnt_r <= cnt_r + CNT_ONE;
          end
        end
        default: begin
          state_r    <= RSTGEN_HOLD;
          cnt_r      <= CNT_ZERO;
          reset_out  <= 1'b1;
          resetn_out <= 1'b0;
        end
      endcase
    end
  end

endmodule
